// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the RV64M divide sequencer.
// Decode, execute and div_ctrl all use this package.
package div_ctrl_pkg;

    localparam int                XLEN        = 64;
    localparam int                CNT_W       = 7;
    localparam logic [CNT_W-1:0]  DIV_ITERS_W = 7'd32;
    localparam logic [CNT_W-1:0]  DIV_ITERS_D = 7'd64;

    typedef struct packed {
        logic is_w;
        logic is_rem;
        logic is_unsigned;
    } div_op_t;

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} div_state_t;

    typedef enum logic [1:0] {SPC_NONE, SPC_DIVZ, SPC_OVF} div_special_t;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // Sign restore, RISC-V corner-case results and W-form sign extension.
    function automatic logic [XLEN-1:0] fix_result(
        input div_op_t         op,
        input div_special_t    spc,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] quot,
        input logic [XLEN-1:0] rem,
        input logic            neg_a,
        input logic            neg_b
    );
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] res;
        case (spc)
            SPC_DIVZ: begin
                q = '1;
                r = a;
            end
            SPC_OVF: begin
                q = a;
                r = '0;
            end
            default: begin
                q = (neg_a ^ neg_b) ? -quot : quot;
                r = neg_a ? -rem : rem;
            end
        endcase
        res = op.is_rem ? r : q;
        return op.is_w ? sext32(res) : res;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
interface div_ctrl_if;
    import div_ctrl_pkg::*;

    logic            in_valid;
    div_op_t         in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            flush;
    logic            in_ready;
    logic            busy;
    logic            out_valid;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, flush,
        input  in_ready, busy, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, flush,
        output in_ready, busy, out_valid, out_result
    );

endinterface

// File: rtl/div_ctrl_core.sv
// Restoring unsigned divider, one quotient bit per clock, MSB-first from bit iters-1.
// The start cycle already produces the first bit, so done rises after exactly iters edges.
module div_ctrl_core
    import div_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_iters,
    input  logic [XLEN-1:0]  i_dividend,
    input  logic [XLEN-1:0]  i_divisor,
    output logic [XLEN-1:0]  o_quot,
    output logic [XLEN-1:0]  o_rem,
    output logic             o_done
);

    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_dvd;
    logic [XLEN-1:0]  r_dvs;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    logic [CNT_W-1:0] w_shamt;
    logic [XLEN-1:0]  w_src_rem;
    logic [XLEN-1:0]  w_src_quot;
    logic [XLEN-1:0]  w_src_dvd;
    logic [XLEN-1:0]  w_src_dvs;
    logic [CNT_W-1:0] w_src_cnt;
    logic [XLEN:0]    w_trial;
    logic [XLEN-1:0]  w_diff;
    logic             w_fits;
    logic             w_step;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_shamt    = CNT_W'(XLEN) - i_iters;
        w_src_rem  = r_rem;
        w_src_quot = r_quot;
        w_src_dvd  = r_dvd;
        w_src_dvs  = r_dvs;
        w_src_cnt  = r_count;
        if (i_start) begin
            w_src_rem  = '0;
            w_src_quot = '0;
            w_src_dvd  = i_dividend << w_shamt;
            w_src_dvs  = i_divisor;
            w_src_cnt  = i_iters;
        end
        w_trial = {w_src_rem, w_src_dvd[XLEN-1]};
        w_fits  = (w_trial >= {1'b0, w_src_dvs});
        // Only used when the divisor fits, so the true difference is below 2^XLEN.
        w_diff  = w_trial[XLEN-1:0] - w_src_dvs;
        w_step  = i_start || (r_count != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem   <= '0;
            r_quot  <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (i_abort) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (w_step) begin
            r_rem   <= w_fits ? w_diff : w_trial[XLEN-1:0];
            r_quot  <= {w_src_quot[XLEN-2:0], w_fits};
            r_dvd   <= {w_src_dvd[XLEN-2:0], 1'b0};
            r_dvs   <= w_src_dvs;
            r_count <= w_src_cnt - CNT_W'(1);
            r_done  <= (w_src_cnt == CNT_W'(1));
        end else begin
            r_done  <= 1'b0;
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_done = r_done;

endmodule

// File: rtl/div_ctrl.sv
// RV64M divide sequencer: operand capture, sign handling, corner cases and result timing
// around an iterative unsigned divider core.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] W_ITERS = DIV_ITERS_W,
    parameter logic [CNT_W-1:0] D_ITERS = DIV_ITERS_D
) (
    input  logic       clk,
    input  logic       reset,
    div_ctrl_if.slave  bus
);

    div_state_t      r_state;
    div_state_t      w_next;
    div_op_t         r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_out_result;

    logic            w_accept;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic [XLEN-1:0] w_min;
    div_special_t    w_spc_in;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_core_done;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_fix_result;
    logic            w_load_out;

    assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.flush;

    // Bring W operands up to 64 bits and classify the request before it is latched.
    always_comb begin
        w_a_ext = bus.in_a;
        w_b_ext = bus.in_b;
        w_min   = {1'b1, {(XLEN-1){1'b0}}};
        if (bus.in_op.is_w) begin
            w_a_ext = bus.in_op.is_unsigned ? {32'b0, bus.in_a[31:0]} : sext32(bus.in_a);
            w_b_ext = bus.in_op.is_unsigned ? {32'b0, bus.in_b[31:0]} : sext32(bus.in_b);
            w_min   = {{33{1'b1}}, 31'b0};
        end
        w_spc_in = SPC_NONE;
        if (w_b_ext == '0) begin
            w_spc_in = SPC_DIVZ;
        end else if (!bus.in_op.is_unsigned && (w_b_ext == '1) && (w_a_ext == w_min)) begin
            w_spc_in = SPC_OVF;
        end
    end

    assign w_neg_a = !r_op.is_unsigned && r_a[XLEN-1];
    assign w_neg_b = !r_op.is_unsigned && r_b[XLEN-1];
    assign w_mag_a = w_neg_a ? -r_a : r_a;
    assign w_mag_b = w_neg_b ? -r_b : r_b;

    div_ctrl_core u_core (
        .clk        (clk),
        .reset      (reset),
        .i_start    (r_state == PREP),
        .i_abort    (bus.flush),
        .i_iters    (r_op.is_w ? W_ITERS : D_ITERS),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_done     (w_core_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (w_spc_in == SPC_NONE) ? PREP : FIX;
            PREP:    w_next = CALC;
            CALC:    if (w_core_done) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.flush) w_next = IDLE;
    end

    // Special cases resolve from the live request; iterated ops from the latched operands.
    always_comb begin
        if (r_state == IDLE) begin
            w_fix_result = fix_result(bus.in_op, w_spc_in, w_a_ext, '0, '0, 1'b0, 1'b0);
        end else begin
            w_fix_result = fix_result(r_op, SPC_NONE, r_a, w_quot, w_rem, w_neg_a, w_neg_b);
        end
        w_load_out = (w_next == FIX) && (r_state != FIX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_out_result <= '0;
        end else begin
            if (w_accept) begin
                r_op <= bus.in_op;
                r_a  <= w_a_ext;
                r_b  <= w_b_ext;
            end
            if (w_load_out) begin
                r_out_result <= w_fix_result;
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.out_valid  = (r_state == FIX) && !bus.flush;
    assign bus.out_result = r_out_result;

endmodule
